// File: rtl/core_ex_muldiv_seq_if.sv
// Handshake bundle between the EX stage and the multi-cycle mul/div unit.
// Slave is the execution unit; master is the EX-stage control.
interface core_ex_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_in1;
  logic [XLEN-1:0] i_in2;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport slave (
    input  i_valid, i_funct3, i_in1, i_in2, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );

  modport master (
    output i_valid, i_funct3, i_in1, i_in2, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/core_ex_muldiv_seq.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: latency-configurable multiply,
// restoring radix-2/4 divider, single-cycle fast paths for /0 and signed overflow.
module core_ex_muldiv_seq #(
  parameter int XLEN               = 32,
  parameter int MUL_CYCLES         = 2,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  core_ex_muldiv_seq_if.slave  bus
);

  localparam int ITERS    = XLEN / DIV_BITS_PER_CYCLE;
  localparam int CNT_W    = $clog2(ITERS + 1);
  localparam int MUL_LAST = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef struct packed {
    logic [2:0]      funct3;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
  } req_t;

  req_t req;
  assign req = '{funct3: bus.i_funct3, in1: bus.i_in1, in2: bus.i_in2};

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  // a_q: multiplicand, or dividend magnitude shifting into the quotient
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] res_q, res_d;

  // Multiplier: operands come straight from the request when MUL_CYCLES==1
  logic [XLEN-1:0]   mul_a, mul_b;
  logic [2:0]        mul_f3;
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_ax, mul_bx, mul_prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_a     = (state_q == S_IDLE) ? req.in1    : a_q;
    mul_b     = (state_q == S_IDLE) ? req.in2    : b_q;
    mul_f3    = (state_q == S_IDLE) ? req.funct3 : f3_q;
    mul_a_sgn = (mul_f3 == 3'd1) || (mul_f3 == 3'd2);
    mul_b_sgn = (mul_f3 == 3'd1);
    mul_ax    = {{XLEN{mul_a_sgn & mul_a[XLEN-1]}}, mul_a};
    mul_bx    = {{XLEN{mul_b_sgn & mul_b[XLEN-1]}}, mul_b};
    mul_prod  = mul_ax * mul_bx;
    mul_res   = (mul_f3 == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // Restoring divider step, DIV_BITS_PER_CYCLE quotient bits per clock
  logic [XLEN-1:0] dq;
  logic [XLEN:0]   dr;
  logic [XLEN-1:0] q_fix, r_fix;

  always_comb begin
    dq = a_q;
    dr = rem_q;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      dr = {dr[XLEN-1:0], dq[XLEN-1]};
      dq = {dq[XLEN-2:0], 1'b0};
      if (dr >= {1'b0, b_q}) begin
        dr    = dr - {1'b0, b_q};
        dq[0] = 1'b1;
      end
    end
    q_fix = negq_q ? -dq : dq;
    r_fix = negr_q ? -dr[XLEN-1:0] : dr[XLEN-1:0];
  end

  logic div_sgn, div_zero, div_ovf;
  assign div_sgn  = ~req.funct3[0];
  assign div_zero = (req.in2 == '0);
  assign div_ovf  = div_sgn && (req.in1 == MOST_NEG) && (req.in2 == '1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid && !bus.i_flush) begin
          f3_d  = req.funct3;
          cnt_d = '0;
          rem_d = '0;
          if (!req.funct3[2]) begin
            a_d = req.in1;
            b_d = req.in2;
            if (MUL_CYCLES == 1) begin
              res_d   = mul_res;
              state_d = S_DONE;
            end else begin
              state_d = S_MUL;
            end
          end else if (div_zero) begin
            res_d   = req.funct3[1] ? req.in1 : '1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            res_d   = req.funct3[1] ? '0 : MOST_NEG;
            state_d = S_DONE;
          end else begin
            a_d     = (div_sgn && req.in1[XLEN-1]) ? -req.in1 : req.in1;
            b_d     = (div_sgn && req.in2[XLEN-1]) ? -req.in2 : req.in2;
            negq_d  = div_sgn && (req.in1[XLEN-1] ^ req.in2[XLEN-1]);
            negr_d  = div_sgn && req.in1[XLEN-1];
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(MUL_LAST)) begin
          res_d   = mul_res;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else begin
          a_d   = dq;
          rem_d = dr;
          cnt_d = cnt_q + CNT_W'(1);
          // Sign correction folds into the last iteration to hit ITERS+1 latency
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            res_d   = f3_q[1] ? r_fix : q_fix;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        if (bus.i_flush || bus.i_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

  assign bus.o_ready  = (state_q == S_IDLE);
  assign bus.o_busy   = (state_q != S_IDLE);
  assign bus.o_valid  = (state_q == S_DONE);
  assign bus.o_result = res_q;

endmodule

// File: tb/tb_core_ex_muldiv_seq.sv
// Randomized and directed bench for core_ex_muldiv_seq against an arithmetic
// reference model (XLEN=32, MUL_CYCLES=2, radix-2 divider).
module tb_core_ex_muldiv_seq;
  localparam int XLEN = 32;
  localparam int MC   = 2;
  localparam int DBPC = 1;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  core_ex_muldiv_seq_if #(.XLEN(XLEN)) bus ();

  core_ex_muldiv_seq #(.XLEN(XLEN), .MUL_CYCLES(MC), .DIV_BITS_PER_CYCLE(DBPC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq;
    longint unsigned ua, ub, uq;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    p = '0;
    case (f)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >> 32; end
      3'd2: begin p = sa * longint'(ub); p = p >> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: if (b == 0) p = '1;
            else if (a == MINV && b == 32'hFFFF_FFFF) p = {32'h0, MINV};
            else begin sq = sa / sb; p = sq; end
      3'd5: if (b == 0) p = '1; else begin uq = ua / ub; p = uq; end
      3'd6: if (b == 0) p = {32'h0, a};
            else if (a == MINV && b == 32'hFFFF_FFFF) p = '0;
            else begin sq = sa % sb; p = sq; end
      default: if (b == 0) p = {32'h0, a}; else begin uq = ua % ub; p = uq; end
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f < 3'd4) return MC;
    if (b == 0) return 1;
    if (!f[0] && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return XLEN / DBPC + 1;
  endfunction

  // Presents a request and returns just after the accepting edge, scrambling the operands
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.i_valid = 1'b1; bus.i_funct3 = f; bus.i_in1 = a; bus.i_in2 = b;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_funct3 = 3'($urandom); bus.i_in1 = $urandom; bus.i_in2 = $urandom;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_r;
    int exp_l, lat;
    exp_r = ref_res(f, a, b);
    exp_l = ref_lat(f, a, b);
    issue(f, a, b);
    lat = 1;
    while (bus.o_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    cmp_cnt++;
    if (lat !== exp_l) begin
      err_cnt++; $display("FAIL %s latency: got %0d want %0d (f3=%0d a=%h b=%h)", tag, lat, exp_l, f, a, b);
    end
    cmp_cnt++;
    if (bus.o_result !== exp_r) begin
      err_cnt++; $display("FAIL %s result: got %h want %h (f3=%0d a=%h b=%h)", tag, bus.o_result, exp_r, f, a, b);
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    cmp_cnt++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      err_cnt++; $display("FAIL %s release: ready=%b valid=%b want 1/0", tag, bus.o_ready, bus.o_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.i_valid = 0; bus.i_ready = 0; bus.i_flush = 0; bus.i_funct3 = 0; bus.i_in1 = 0; bus.i_in2 = 0;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++;
    if ({bus.o_ready, bus.o_valid, bus.o_busy} !== 3'b100 || bus.o_result !== 32'h0) begin
      err_cnt++; $display("FAIL reset: rdy/vld/busy=%b result=%h want 100/0", {bus.o_ready, bus.o_valid, bus.o_busy}, bus.o_result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    run_op(3'd0, 32'h7, 32'hFFFF_FFFD, "mul");
    run_op(3'd1, 32'h7, 32'hFFFF_FFFD, "mulh");
    run_op(3'd3, 32'h7, 32'hFFFF_FFFD, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFEC, 32'h3, "div");
    run_op(3'd6, 32'hFFFF_FFEC, 32'h3, "rem");
    run_op(3'd5, 32'h64, 32'h0, "divu_zero");
    run_op(3'd7, 32'h64, 32'h0, "remu_zero");
    run_op(3'd4, MINV, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, MINV, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'd5, 32'hFFFF_FFFF, 32'h1, "divu_max");
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [2:0] f;
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = MINV; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
        3: b = $urandom_range(1, 7) | 32'hFFFF_FFF0;
        default: ;
      endcase
      run_op(f, a, b, "random");
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_r;
    int k;
    exp_r = ref_res(3'd0, 32'h1234, 32'h5678);
    issue(3'd0, 32'h1234, 32'h5678);
    k = 0;
    while (bus.o_valid !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
    for (int i = 0; i < 5; i++) begin
      cmp_cnt++;
      if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_result !== exp_r) begin
        err_cnt++; $display("FAIL backpressure cycle %0d: valid=%b ready=%b result=%h want 1/0/%h", i, bus.o_valid, bus.o_ready, bus.o_result, exp_r);
      end
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    cmp_cnt++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      err_cnt++; $display("FAIL backpressure release: ready=%b valid=%b want 1/0", bus.o_ready, bus.o_valid);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    issue(3'd0, 32'h3, 32'h5);
    k = 0;
    while (bus.o_valid !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
    // Next request is already pending while the result is consumed
    bus.i_valid = 1'b1; bus.i_funct3 = 3'd0; bus.i_in1 = 32'h9; bus.i_in2 = 32'hB;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    cmp_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin
      err_cnt++; $display("FAIL b2b same-cycle accept: busy=%b ready=%b want 0/1", bus.o_busy, bus.o_ready);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    k = 1;
    while (bus.o_valid !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
    cmp_cnt++;
    if (k !== MC || bus.o_result !== 32'd99) begin
      err_cnt++; $display("FAIL b2b second op: lat=%0d result=%h want %0d/%h", k, bus.o_result, MC, 32'd99);
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic test_flush;
    issue(3'd4, 32'hFFFF_FFEC, 32'h3);
    repeat (9) begin @(posedge clk); #1; end
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    cmp_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      err_cnt++; $display("FAIL flush div: busy=%b ready=%b valid=%b want 0/1/0", bus.o_busy, bus.o_ready, bus.o_valid);
    end
    // Flush in IDLE must win over a simultaneous request
    bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_funct3 = 3'd0;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    cmp_cnt++;
    if (bus.o_busy !== 1'b0) begin
      err_cnt++; $display("FAIL flush idle: busy=%b want 0", bus.o_busy);
    end
    repeat (30) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (bus.o_valid !== 1'b0) begin
        err_cnt++; $display("FAIL flush leak: valid=%b want 0", bus.o_valid);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    issue(3'd0, 32'hFFFF_0001, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({bus.o_ready, bus.o_valid, bus.o_busy} !== 3'b100 || bus.o_result !== 32'h0) begin
      err_cnt++; $display("FAIL reset mid-mul: rdy/vld/busy=%b result=%h want 100/0", {bus.o_ready, bus.o_valid, bus.o_busy}, bus.o_result);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (bus.o_valid !== 1'b0) begin
        err_cnt++; $display("FAIL reset mid-mul leak: valid=%b want 0", bus.o_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_directed();
    test_reset_mid_mul();
    run_op(3'd6, 32'h0000_0007, 32'hFFFF_FFFE, "post_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
